gate_truth_sequencer: RTL and testbench
=======================================

Name: gate_truth_sequencer

Overview:
- Upstream/downstream companion to the 2-input combinational gate blocks.
- Drives every input pattern into a gate-under-test, waits a settle window, samples the gate output, and checks it against an expected truth table.
- Reports pass/fail, mismatch count and first failing pattern through a start/done handshake.
- Replaces hand-written per-gate stimulus with one synthesizable self-checking stage.

Parameters:
- N_IN, 2, number of gate inputs (1..4); patterns 0..2^N_IN-1.
- EXPECT, 4'b1110, expected truth table, width 2^N_IN; bit i = expected output for pattern i (default = OR).
- SETTLE, 1, cycles from drv update to sample (1..15).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level-sampled run request; honoured only in IDLE.
- drv  out  N_IN  gate-input pattern; drv[N_IN-1]=a (MSB) ... drv[0]=b; pattern index i = drv.
- gate_out  in  1  output of gate-under-test.
- busy  out  1  high while a run is in progress.
- done  out  1  one-cycle pulse at run completion.
- pass  out  1  1 when last run had zero mismatches; valid from done, held until next start.
- err_count  out  N_IN+1  mismatches in last run (0..2^N_IN, never wraps).
- first_fail  out  N_IN  lowest failing pattern index of last run.
- fail_valid  out  1  high when first_fail is meaningful (err_count != 0).

Behaviour:
- All outputs registered; no combinational path from gate_out or start to any output.
- Reset (rst=1 at clk edge): state=IDLE; drv=0, busy=0, done=0, pass=0, err_count=0, first_fail=0, fail_valid=0, settle counter=0. Reset overrides all other inputs.
- States: IDLE, RUN.
- IDLE, start=1 at edge:
  - drv<=0, busy<=1, err_count<=0, first_fail<=0, fail_valid<=0, pass<=0, cnt<=SETTLE-1; go RUN.
- IDLE, start=0: hold all outputs; done<=0.
- RUN, cnt!=0: cnt<=cnt-1; drv held.
- RUN, cnt==0 (sample edge):
  - Compare gate_out with EXPECT[drv].
  - On mismatch: err_count<=err_count+1; if fail_valid==0, first_fail<=drv and fail_valid<=1.
  - If drv != 2^N_IN-1: drv<=drv+1, cnt<=SETTLE-1.
  - If drv == 2^N_IN-1: busy<=0, done<=1, drv<=0, pass<=(final mismatch total == 0), including this sample; go IDLE.
- Timing:
  - Each pattern is held exactly SETTLE cycles; gate_out is sampled on the SETTLE-th edge after drv changes.
  - Latency from start-accept edge to done-assert edge = 2^N_IN*SETTLE edges.
- done is high for exactly one cycle; cleared on the following edge.
- start while busy: ignored, no restart, no effect on counters.
- start high in the cycle done is high: accepted at that edge (state is already IDLE). A new run begins, done falls, results clear.
- start held continuously: back-to-back runs, each separated by one IDLE cycle.
- Reset mid-run: run aborted, reset values applied, no done pulse.
- Results (pass, err_count, first_fail, fail_valid) are stable from done until the next accepted start.

Test Plan:
- N_IN=2, SETTLE=1, gate_out = a|b of drv, pulse start -> drv 0,1,2,3 on consecutive cycles; done 4 edges after start; pass=1, err_count=0, fail_valid=0.
- gate_out stuck at 0 -> err_count=3, first_fail=1, fail_valid=1, pass=0.
- gate_out = ~(a|b) (NOR) -> err_count=4 (no wrap), first_fail=0, pass=0.
- SETTLE=3, correct OR -> each drv value held 3 cycles; done exactly 12 edges after start; pass=1.
- Pulse start again at cycle 2 of a run -> ignored, done still at edge 4, err_count unchanged. Then rst=1 at cycle 2 of a fresh run -> all outputs 0 next edge, no done.
- start held high continuously -> runs repeat; done at edges 4, 9, 14; results clear to 0 on each accept.

Source files
------------

// File: rtl/gate_truth_sequencer.sv
// Self-checking stimulus stage for a small combinational gate.
// Walks every input pattern, waits a settle window, samples the gate output,
// compares it against an expected truth table and reports the run result
// through a start/done handshake.
module gate_truth_sequencer #(
  parameter int unsigned            N_IN   = 2,
  parameter logic [(1<<N_IN)-1:0]   EXPECT = 4'b1110,
  parameter int unsigned            SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] drv,
  input  logic            gate_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail,
  output logic            fail_valid
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned ERR_W = N_IN + 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE - 1);
  localparam logic [N_IN-1:0]  LAST_PAT   = '1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [N_IN-1:0]   drv_q, drv_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [N_IN-1:0]   ff_q, ff_d;
  logic              fv_q, fv_d;

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      drv_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ff_q    <= '0;
      fv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      drv_q   <= drv_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      fv_q    <= fv_d;
    end
  end

  // Next-state logic: accept a run, count down the settle window, then
  // sample, score and advance to the next pattern.
  always_comb begin
    logic             mismatch;
    logic [ERR_W-1:0] err_next;

    state_d  = state_q;
    drv_d    = drv_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    err_d    = err_q;
    ff_d     = ff_q;
    fv_d     = fv_q;
    mismatch = 1'b0;
    err_next = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          drv_d   = '0;
          busy_d  = 1'b1;
          err_d   = '0;
          ff_d    = '0;
          fv_d    = 1'b0;
          pass_d  = 1'b0;
          cnt_d   = CNT_RELOAD;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          mismatch = (gate_out != EXPECT[drv_q]);
          err_next = mismatch ? (err_q + ERR_W'(1)) : err_q;
          err_d    = err_next;
          if (mismatch && !fv_q) begin
            ff_d = drv_q;
            fv_d = 1'b1;
          end
          if (drv_q != LAST_PAT) begin
            drv_d = drv_q + N_IN'(1);
            cnt_d = CNT_RELOAD;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            drv_d   = '0;
            pass_d  = (err_next == '0);
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign drv        = drv_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign first_fail = ff_q;
  assign fail_valid = fv_q;

endmodule

// File: tb/tb_gate_truth_sequencer.sv
// Bench for gate_truth_sequencer: two instances (settle 1 and 3) each
// driving a modelled gate; results checked against a truth-table model.
module tb_gate_truth_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic st;
  logic sel;

  int unsigned gmode;
  logic [3:0]  rt;

  logic       start1, start3;
  logic [1:0] drv1, drv3;
  logic       gate1, gate3;
  logic       busy1, busy3, done1, done3, pass1, pass3, fv1, fv3;
  logic [2:0] err1, err3;
  logic [1:0] ff1, ff3;

  logic [1:0] m_drv;
  logic       m_busy, m_done, m_pass, m_fv;
  logic [2:0] m_err;
  logic [1:0] m_ff;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Gate-under-test behaviour chosen by gmode.
  function automatic logic gfun(input int unsigned mode, input logic [1:0] d,
                                input logic [3:0] tab);
    logic a, b;
    a = d[1];
    b = d[0];
    case (mode)
      0:       return a | b;
      1:       return 1'b0;
      2:       return ~(a | b);
      default: return tab[d];
    endcase
  endfunction

  assign gate1  = gfun(gmode, drv1, rt);
  assign gate3  = gfun(gmode, drv3, rt);
  assign start1 = st & ~sel;
  assign start3 = st & sel;

  assign m_drv  = sel ? drv3  : drv1;
  assign m_busy = sel ? busy3 : busy1;
  assign m_done = sel ? done3 : done1;
  assign m_pass = sel ? pass3 : pass1;
  assign m_err  = sel ? err3  : err1;
  assign m_ff   = sel ? ff3   : ff1;
  assign m_fv   = sel ? fv3   : fv1;

  gate_truth_sequencer #(.N_IN(2), .EXPECT(4'b1110), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .drv(drv1), .gate_out(gate1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_fail(ff1), .fail_valid(fv1));

  gate_truth_sequencer #(.N_IN(2), .EXPECT(4'b1110), .SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .drv(drv3), .gate_out(gate3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .first_fail(ff3), .fail_valid(fv3));

  // Reference: an OR gate is expected; score every pattern of the modelled gate.
  function automatic void model(input int unsigned mode, input logic [3:0] tab,
                                output int errs, output int first, output bit fvalid);
    errs = 0; first = 0; fvalid = 0;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] p;
      bit want;
      p = 2'(i);
      want = ((i / 2) != 0) || ((i % 2) != 0);
      if (gfun(mode, p, tab) != logic'(want)) begin
        errs++;
        if (!fvalid) begin first = i; fvalid = 1; end
      end
    end
  endfunction

  int          lat;
  bit          got_done;
  logic [1:0]  seq[$];

  // Start one run on the selected instance and follow it to done (bounded).
  task automatic do_run();
    st = 1'b1;
    @(posedge clk); #1;
    st = 1'b0;
    seq.delete();
    seq.push_back(m_drv);
    lat = 0;
    got_done = 0;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (m_done) begin got_done = 1; break; end
      seq.push_back(m_drv);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; st = 1'b0; sel = 1'b0; gmode = 0; rt = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({drv1, busy1, done1, pass1, err1, ff1, fv1} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_dut1 got %b want 0", {drv1, busy1, done1, pass1, err1, ff1, fv1});
    end
    n_checks++;
    if ({drv3, busy3, done3, pass3, err3, ff3, fv3} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_dut3 got %b want 0", {drv3, busy3, done3, pass3, err3, ff3, fv3});
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_or_pass();
    sel = 1'b0; gmode = 0;
    do_run();
    n_checks++;
    if (!got_done || lat != 4) begin
      n_fail++; $display("FAIL or_latency got %0d (done=%0b) want 4", lat, got_done);
    end
    n_checks++;
    if (seq.size() != 4 || seq[0] !== 2'd0 || seq[1] !== 2'd1 || seq[2] !== 2'd2 || seq[3] !== 2'd3) begin
      n_fail++; $display("FAIL or_drv_seq got %p want 0,1,2,3", seq);
    end
    n_checks++;
    if ({m_pass, m_err, m_fv, m_busy, m_drv} !== {1'b1, 3'd0, 1'b0, 1'b0, 2'd0}) begin
      n_fail++; $display("FAIL or_result got pass=%0b err=%0d fv=%0b busy=%0b drv=%0d want 1,0,0,0,0",
                         m_pass, m_err, m_fv, m_busy, m_drv);
    end
    @(posedge clk); #1;
    n_checks++;
    if (m_done !== 1'b0 || m_pass !== 1'b1) begin
      n_fail++; $display("FAIL or_done_pulse got done=%0b pass=%0b want 0,1", m_done, m_pass);
    end
  endtask

  task automatic test_stuck0();
    sel = 1'b0; gmode = 1;
    do_run();
    n_checks++;
    if (!got_done || {m_err, m_ff, m_fv, m_pass} !== {3'd3, 2'd1, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL stuck0 got err=%0d ff=%0d fv=%0b pass=%0b want 3,1,1,0",
                         m_err, m_ff, m_fv, m_pass);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_nor();
    sel = 1'b0; gmode = 2;
    do_run();
    n_checks++;
    if (!got_done || {m_err, m_ff, m_fv, m_pass} !== {3'd4, 2'd0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL nor got err=%0d ff=%0d fv=%0b pass=%0b want 4,0,1,0",
                         m_err, m_ff, m_fv, m_pass);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_settle3();
    bit seq_ok;
    sel = 1'b1; gmode = 0;
    do_run();
    n_checks++;
    if (!got_done || lat != 12) begin
      n_fail++; $display("FAIL settle3_latency got %0d want 12", lat);
    end
    seq_ok = (seq.size() == 12);
    for (int k = 0; k < seq.size() && k < 12; k++)
      if (seq[k] !== 2'(k / 3)) seq_ok = 0;
    n_checks++;
    if (!seq_ok) begin
      n_fail++; $display("FAIL settle3_drv_seq got %p want each value held 3 cycles", seq);
    end
    n_checks++;
    if (m_pass !== 1'b1 || m_err !== 3'd0) begin
      n_fail++; $display("FAIL settle3_result got pass=%0b err=%0d want 1,0", m_pass, m_err);
    end
    @(posedge clk); #1;
    sel = 1'b0;
  endtask

  task automatic test_start_while_busy();
    bit saw_done;
    sel = 1'b0; gmode = 1;
    st = 1'b1;
    @(posedge clk); #1;
    st = 1'b0;
    lat = 0; got_done = 0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      st = (lat == 2);
      if (m_done) begin got_done = 1; break; end
    end
    st = 1'b0;
    n_checks++;
    if (!got_done || lat != 4 || m_err !== 3'd3) begin
      n_fail++; $display("FAIL busy_start got lat=%0d err=%0d want 4,3", lat, m_err);
    end
    @(posedge clk); #1;
    n_checks++;
    if (m_busy !== 1'b0) begin
      n_fail++; $display("FAIL busy_start_norestart got busy=%0b want 0", m_busy);
    end
    // Reset in the middle of a fresh run.
    st = 1'b1;
    @(posedge clk); #1;
    st = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if ({m_drv, m_busy, m_done, m_pass, m_err, m_ff, m_fv} !== 11'd0) begin
      n_fail++; $display("FAIL midrun_reset got %b want 0", {m_drv, m_busy, m_done, m_pass, m_err, m_ff, m_fv});
    end
    saw_done = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (m_done || m_busy) saw_done = 1;
    end
    n_checks++;
    if (saw_done) begin
      n_fail++; $display("FAIL midrun_no_done got activity=1 want 0");
    end
  endtask

  task automatic test_back_to_back();
    int dq[$];
    int accepts_ok;
    int guard;
    sel = 1'b0; gmode = 1;
    st = 1'b1;
    @(posedge clk); #1;
    accepts_ok = 1;
    for (int e = 1; e <= 15; e++) begin
      @(posedge clk); #1;
      if (m_done) dq.push_back(e);
      if ((e == 5 || e == 10) && (m_err !== 3'd0 || m_fv !== 1'b0 || m_busy !== 1'b1))
        accepts_ok = 0;
    end
    st = 1'b0;
    n_checks++;
    if (dq.size() != 3 || dq[0] != 4 || dq[1] != 9 || dq[2] != 14) begin
      n_fail++; $display("FAIL b2b_done_edges got %p want 4,9,14", dq);
    end
    n_checks++;
    if (!accepts_ok) begin
      n_fail++; $display("FAIL b2b_results_clear got not cleared want err=0 fv=0 busy=1 on accept");
    end
    guard = 0;
    while (m_busy && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    n_checks++;
    if (m_busy) begin
      n_fail++; $display("FAIL b2b_drain got busy=1 want 0");
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int e_err, e_ff;
    bit e_fv;
    for (int it = 0; it < 24; it++) begin
      sel   = 1'($urandom_range(0, 1));
      gmode = $urandom_range(0, 3);
      rt    = 4'($urandom);
      model(gmode, rt, e_err, e_ff, e_fv);
      do_run();
      n_checks++;
      if (!got_done || lat != (sel ? 12 : 4) ||
          m_err !== 3'(e_err) || m_fv !== e_fv || (e_fv && m_ff !== 2'(e_ff)) ||
          m_pass !== (e_err == 0)) begin
        n_fail++;
        $display("FAIL random_%0d got lat=%0d err=%0d ff=%0d fv=%0b pass=%0b want lat=%0d err=%0d ff=%0d fv=%0b",
                 it, lat, m_err, m_ff, m_fv, m_pass, sel ? 12 : 4, e_err, e_ff, e_fv);
      end
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_or_pass();
    test_stuck0();
    test_nor();
    test_settle3();
    test_start_while_busy();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
